// File: rtl/motion_history_ctrl_if.sv
// Camera, display-read, BRAM-port and status signals of motion_history_ctrl.
// master = the controller, slave = the camera/display/BRAM environment.
interface motion_history_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              cam_valid;
    logic              cam_frame_start;
    logic [2:0]        cam_pixel;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [8:0]        rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [8:0]        mem_wdata;
    logic [8:0]        mem_rdata;
    logic [1:0]        frame_chunk_counter;
    logic              overrun;

    modport master (
        input  cam_valid, cam_frame_start, cam_pixel, rd_req, rd_addr, mem_rdata,
        output rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata,
               frame_chunk_counter, overrun
    );

    modport slave (
        output cam_valid, cam_frame_start, cam_pixel, rd_req, rd_addr, mem_rdata,
        input  rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata,
               frame_chunk_counter, overrun
    );
endinterface

// File: rtl/motion_history_ctrl.sv
// Frame-history BRAM sequencer: camera pixel RMW into per-frame 3-bit chunks plus display reads.
// Optional MOTION_CLEAR_EN: zero the whole frame after reset before serving traffic.
module motion_history_ctrl #(
    parameter int ADDR_W     = 17,
    parameter int LAST_ADDR  = 76799,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    motion_history_ctrl_if.master bus
);
    localparam int                PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);
    localparam logic [PTR_W:0]    FULL  = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        chunk;
        logic [2:0]        pix;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_DISP,
        S_RD_CAM,
`ifdef MOTION_CLEAR_EN
        S_WR_CAM,
        S_CLEAR
`else
        S_WR_CAM
`endif
    } state_t;

    state_t            r_state, w_next;
    entry_t            r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_wa;
    logic [1:0]        r_chunk;
    logic              r_overrun;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_valid;
`ifdef MOTION_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_addr;
`endif

    logic              w_sample, w_sat, w_full, w_clearing, w_push, w_drop, w_pop;
    logic [1:0]        w_next_chunk;
    entry_t            w_entry, w_head;
    logic [8:0]        w_merged;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we, w_ack;
    logic [8:0]        w_wdata;

    // Only a non-start pixel arriving with wa already at the last address is discarded.
    assign w_sample     = bus.cam_valid;
    assign w_sat        = w_sample & ~bus.cam_frame_start & (r_wa == LAST);
    assign w_next_chunk = (r_chunk == 2'd2) ? 2'd0 : r_chunk + 2'd1;
    assign w_full       = (r_count == FULL);
`ifdef MOTION_CLEAR_EN
    assign w_clearing   = (r_state == S_CLEAR);
`else
    assign w_clearing   = 1'b0;
`endif
    assign w_push       = w_sample & ~w_sat & ~w_full & ~w_clearing;
    assign w_drop       = w_sample & ~w_sat &  w_full & ~w_clearing;

    assign w_entry.addr  = bus.cam_frame_start ? '0 : r_wa + 1'b1;
    assign w_entry.chunk = bus.cam_frame_start ? w_next_chunk : r_chunk;
    assign w_entry.pix   = bus.cam_pixel;
    assign w_head        = r_fifo[r_rd_ptr];

    always_comb begin
        w_merged = bus.mem_rdata;
        case (w_head.chunk)
            2'd0:    w_merged[8:6] = w_head.pix;
            2'd1:    w_merged[5:3] = w_head.pix;
            default: w_merged[2:0] = w_head.pix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wa      <= '0;
            r_chunk   <= 2'd2;
            r_overrun <= 1'b0;
        end else begin
            if (w_sample && bus.cam_frame_start) begin
                r_wa    <= '0;
                r_chunk <= w_next_chunk;
            end else if (w_sample && !w_sat) begin
                r_wa <= r_wa + 1'b1;
            end
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef MOTION_CLEAR_EN
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
`else
            r_state    <= S_IDLE;
`endif
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= (r_state == S_RD_DISP);
            if (r_state == S_IDLE && bus.rd_req) r_rd_addr <= bus.rd_addr;
`ifdef MOTION_CLEAR_EN
            if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
`endif
        end
    end

    // Display reads win in IDLE; a camera RMW, once started, always completes.
    always_comb begin
        w_next  = r_state;
        w_addr  = '0;
        w_we    = 1'b0;
        w_wdata = '0;
        w_ack   = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rd_req)        w_next = S_RD_DISP;
                else if (r_count != 0) w_next = S_RD_CAM;
            end
            S_RD_DISP: begin
                w_addr = r_rd_addr;
                w_ack  = 1'b1;
                w_next = S_IDLE;
            end
            S_RD_CAM: begin
                w_addr = w_head.addr;
                w_next = S_WR_CAM;
            end
            S_WR_CAM: begin
                w_addr  = w_head.addr;
                w_we    = 1'b1;
                w_wdata = w_merged;
                w_pop   = 1'b1;
                w_next  = S_IDLE;
            end
`ifdef MOTION_CLEAR_EN
            S_CLEAR: begin
                // Reset holds the FSM in CLEAR; keep the write strobe off until it releases.
                w_addr = r_clr_addr;
                w_we   = ~reset;
                if (r_clr_addr == LAST) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.mem_addr            = w_addr;
    assign bus.mem_we              = w_we;
    assign bus.mem_wdata           = w_wdata;
    assign bus.rd_ack              = w_ack;
    assign bus.rd_valid            = r_rd_valid;
    assign bus.rd_data             = r_rd_valid ? bus.mem_rdata : 9'h000;
    assign bus.frame_chunk_counter = r_chunk;
    assign bus.overrun             = r_overrun;
endmodule

// File: doc/motion_history_ctrl.md
# motion_history_ctrl

Sequences the shared 9-bit frame-history BRAM that feeds the temporal motion filter. Camera pixels (3-bit) are buffered, then written by read-modify-write into the chunk of each word that belongs to the current frame. VGA-side word reads are arbitrated onto the same single memory port. The block also owns `frame_chunk_counter`, which goes to the filter.

## Interface
Parameters:
- `ADDR_W`, 17: BRAM address width.
- `LAST_ADDR`, 76799: last pixel address of a frame (320x240 − 1).
- `FIFO_DEPTH`, 4: camera pixel buffer entries; must be a power of two.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `cam_valid`  in  1: camera pixel strobe; the camera cannot stall.
- `cam_frame_start`  in  1: qualifies `cam_valid`; marks the first pixel of a frame.
- `cam_pixel`  in  3: camera pixel value.
- `rd_req`  in  1: display read request; held high until `rd_ack`.
- `rd_addr`  in  ADDR_W: display read address; stable while `rd_req` is high.
- `rd_ack`  out  1: one-cycle pulse; request taken.
- `rd_valid`  out  1: one-cycle pulse; `rd_data` is valid.
- `rd_data`  out  9: BRAM word returned to the display/filter.
- `mem_addr`  out  ADDR_W: BRAM address.
- `mem_we`  out  1: BRAM write enable.
- `mem_wdata`  out  9: BRAM write data.
- `mem_rdata`  in  9: BRAM read data; synchronous, valid the cycle after the address is presented.
- `frame_chunk_counter`  out  2: chunk index of the frame being written (0, 1, 2).
- `overrun`  out  1: sticky; a camera pixel was dropped.

## Operation
- **Chunk map:** counter 0 → bits [8:6], 1 → [5:3], 2 → [2:0].
  - The counter advances 0→1→2→0 when a `cam_frame_start` pixel is sampled.
  - Reset value is 2, so the first frame writes chunk 0.
- **Camera write-address counter `wa`:**
  - Loads 0 on a frame-start pixel; otherwise increments on every sampled pixel.
  - Saturates at `LAST_ADDR`. Pixels sampled while `wa == LAST_ADDR`, after the first, are discarded silently; `overrun` is not set.
- **FIFO contents:** each entry holds {`wa`, chunk, pixel}. The chunk is captured at push, so in-flight pixels keep their frame's chunk across a counter advance.
- **FIFO full:** a sampled pixel is dropped and `overrun` is set. `wa` still advances so raster alignment is kept.
- **FSM states:** IDLE, RD_DISP, RD_CAM, WR_CAM, plus CLEAR when it is compiled in.
  - **IDLE:** if `rd_req`, latch `rd_addr` → RD_DISP. Otherwise, if the FIFO is non-empty → RD_CAM. Display requests have fixed priority.
  - **RD_DISP:** `mem_addr` = latched address, `mem_we` = 0, `rd_ack` = 1 → IDLE.
  - **RD_CAM:** `mem_addr` = FIFO head address, `mem_we` = 0 → WR_CAM.
  - **WR_CAM:** `mem_addr` = head address, `mem_we` = 1. `mem_wdata` = `mem_rdata` with the head's chunk replaced by its pixel; other chunks pass unchanged. Pop the FIFO → IDLE.
- `rd_valid` = 1 and `rd_data` = `mem_rdata` on the cycle after RD_DISP.
- **Simultaneous FIFO push and pop:** both occur; the occupancy count is unchanged.

## Timing
- **Reset values:** every output is 0 except `frame_chunk_counter` = 2. FIFO is empty, `wa` = 0, and the FSM is in IDLE (or CLEAR when enabled).
- **Reset mid-operation:** the FSM and FIFO abort immediately. A partial RMW is lost, and `mem_we` drops asynchronously.
- **Display read latency:** `rd_req` seen in IDLE at cycle C gives `rd_ack`/RD_DISP at C+1 and `rd_valid` at C+2. A new request is sampled no earlier than C+2.
- If `rd_req` arrives while the FSM is in RD_CAM, the current RMW finishes first. Worst-case `rd_ack` is 3 cycles after `rd_req`.
- **Camera RMW:** 3 cycles including the IDLE decision. Only the WR_CAM cycle asserts `mem_we`.
- **Pixel timing:** a pixel sampled at cycle P can be in the BRAM at P+3 at the earliest (FIFO was empty, no display traffic).
- **Counter timing:** `frame_chunk_counter` and `wa` update on the clock edge that samples the frame-start pixel.

## Configuration
- **`MOTION_CLEAR_EN` defined:**
  - After reset, the FSM enters CLEAR and writes 9'h000 to addresses 0..`LAST_ADDR`, one per cycle.
  - During CLEAR, `rd_ack` is withheld and camera pixels are dropped without setting `overrun`.
  - CLEAR → IDLE after `LAST_ADDR` is written.
- **Undefined:** no CLEAR state; the FSM leaves reset in IDLE and memory contents are whatever the BRAM holds.

## Test plan
- **Reset defaults:** reset → all outputs 0 and `frame_chunk_counter` = 2. Release with no traffic → `mem_we` never rises.
- **First frame write:** frame-start pixel 3'b101, BRAM word 0 = 9'h1FF → counter = 0 and word 0 becomes 9'b101_111_111 at the WR_CAM cycle.
- **Chunk rotation:** three frames of one pixel each, values 1, 2, 3, word 0 initially 0 → final word 0 = 9'b001_010_011 and the counter reads 2.
- **Arbitration:** `rd_req` (addr 5) and a camera pixel arrive in the same cycle → `rd_ack` is 1 cycle later, `rd_valid` 2 cycles later, and the camera write follows RD_DISP.
- **Overrun:** hold `rd_req` continuously and send 6 pixels with `FIFO_DEPTH` = 4 → some pixels are dropped and `overrun` = 1.
  - Each surviving pixel lands at its own raster address (the address it would have had with no drops).
- **`MOTION_CLEAR_EN`:** defined → `mem_we` high for exactly `LAST_ADDR`+1 cycles after reset and `rd_ack` is withheld until then.
